out_fifo_bank: RTL

- Four-lane output buffer that feeds the AXI4 read-response FSM.
- Compute/datapath logic pushes result words into a lane chosen by lane ID.
- The read FSM checks out_fifo_empty for the lane selected by out_fifo_pop_sel and pops it while driving R beats.
- Each lane is first-word-fall-through, so the head word is on out_fifo_data before the pop.

---
 rtl/firework_fifo_pkg.sv | 21 ++
 rtl/out_fifo_lane.sv | 64 ++++++
 rtl/out_fifo_bank.sv | 96 +++++++++
 3 files changed

// File: rtl/firework_fifo_pkg.sv
// Shared constants and types for the output FIFO bank and the read-response FSM
// that selects which lane to pop.
package firework_fifo_pkg;

   localparam int NUM_OUT_LANES   = 4;
   localparam int LANE_SEL_W      = 2;
   localparam int OUT_FIFO_DATA_W = 32;
   localparam int OUT_FIFO_DEPTH  = 16;
   localparam int OUT_FIFO_ADDR_W = $clog2(OUT_FIFO_DEPTH);

   typedef logic [LANE_SEL_W-1:0]    lane_sel_t;
   typedef logic [NUM_OUT_LANES-1:0] lane_mask_t;

   function automatic lane_mask_t lane_onehot(input lane_sel_t sel);
      lane_mask_t mask;
      mask      = '0;
      mask[sel] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/out_fifo_lane.sv
// One first-word-fall-through FIFO lane: storage, pointers and occupancy level.
// Push/pop strobes are qualified here against full/empty.
module out_fifo_lane #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              push_ok, pop_ok;

   assign empty = (level_q == '0);
   assign full  = (level_q == (ADDR_W+1)'(DEPTH));
   assign level = level_q;
   assign rdata = empty ? '0 : mem_q[rptr_q];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      push_ok = push && !full;
      pop_ok  = pop && !empty;
      if (push_ok) wptr_d = wptr_q + ADDR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + ADDR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + (ADDR_W+1)'(1);
         2'b01:   level_d = level_q - (ADDR_W+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // NOTE: storage is deliberately not reset; level==0 masks stale contents on rdata.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/out_fifo_bank.sv
// Four-lane FWFT output buffer between the datapath and the AXI4 read-response FSM,
// with lane push/pop decode, read-side muxes and sticky overflow/underflow flags.
module out_fifo_bank
   import firework_fifo_pkg::*;
#(
   parameter int DATA_W = OUT_FIFO_DATA_W,
   parameter int DEPTH  = OUT_FIFO_DEPTH,
   parameter int ADDR_W = OUT_FIFO_ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  lane_sel_t                in_lane,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   input  logic                     out_fifo_pop,
   input  lane_sel_t                out_fifo_pop_sel,
   output logic                     out_fifo_empty,
   output logic [DATA_W-1:0]        out_fifo_data,
   output logic [NUM_OUT_LANES-1:0] lane_empty,
   output logic [NUM_OUT_LANES-1:0] lane_full,
   output logic [ADDR_W:0]          lane_level0,
   output logic [ADDR_W:0]          lane_level1,
   output logic [ADDR_W:0]          lane_level2,
   output logic [ADDR_W:0]          lane_level3,
   input  logic                     err_clr,
   output logic                     err_overflow,
   output logic                     err_underflow
);

   lane_mask_t        push_vec, pop_vec;
   logic [DATA_W-1:0] lane_rdata [NUM_OUT_LANES];
   logic [ADDR_W:0]   lane_level [NUM_OUT_LANES];
   logic              overflow_evt, underflow_evt;
   logic              err_overflow_q, err_overflow_d;
   logic              err_underflow_q, err_underflow_d;

   assign push_vec = in_valid     ? lane_onehot(in_lane)          : '0;
   assign pop_vec  = out_fifo_pop ? lane_onehot(out_fifo_pop_sel) : '0;

   for (genvar i = 0; i < NUM_OUT_LANES; i++) begin : g_lane
      out_fifo_lane #(
         .DATA_W(DATA_W),
         .DEPTH (DEPTH),
         .ADDR_W(ADDR_W)
      ) u_lane (
         .clk  (clk),
         .reset(reset),
         .push (push_vec[i]),
         .pop  (pop_vec[i]),
         .wdata(in_data),
         .rdata(lane_rdata[i]),
         .empty(lane_empty[i]),
         .full (lane_full[i]),
         .level(lane_level[i])
      );
   end

   // Ready and read-side outputs depend only on selects and registered flags.
   assign in_ready       = !lane_full[in_lane];
   assign out_fifo_empty = lane_empty[out_fifo_pop_sel];
   assign out_fifo_data  = lane_rdata[out_fifo_pop_sel];
   assign lane_level0    = lane_level[0];
   assign lane_level1    = lane_level[1];
   assign lane_level2    = lane_level[2];
   assign lane_level3    = lane_level[3];

   assign overflow_evt  = in_valid && lane_full[in_lane];
   assign underflow_evt = out_fifo_pop && lane_empty[out_fifo_pop_sel];

   // A new error event in the same cycle wins over err_clr.
   always_comb begin
      err_overflow_d  = err_overflow_q;
      err_underflow_d = err_underflow_q;
      if (err_clr) begin
         err_overflow_d  = 1'b0;
         err_underflow_d = 1'b0;
      end
      if (overflow_evt)  err_overflow_d  = 1'b1;
      if (underflow_evt) err_underflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_overflow_q  <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         err_overflow_q  <= err_overflow_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   assign err_overflow  = err_overflow_q;
   assign err_underflow = err_underflow_q;

endmodule
